// File: rtl/psram_if_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : psram_if_responder_if
// Purpose  : User-side command/data bundle of the PSRAM memory interface.
//            The master drives commands and write beats; the slave returns
//            read beats, calibration status and burst statistics.
// Signals  : cmd, cmd_en, addr, wr_data, data_mask   (master -> slave)
//            rd_data, rd_data_valid, init_calib,
//            cmd_err, wr_burst_cnt, rd_burst_cnt     (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface psram_if_responder_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 64
) ();
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   data_mask;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_data_valid;
    logic                  init_calib;
    logic                  cmd_err;
    logic [15:0]           wr_burst_cnt;
    logic [15:0]           rd_burst_cnt;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, init_calib, cmd_err, wr_burst_cnt, rd_burst_cnt
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, init_calib, cmd_err, wr_burst_cnt, rd_burst_cnt
    );
endinterface
`default_nettype wire

// File: rtl/psram_if_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_if_responder
// Purpose  : Behavioural-timing stand-in for the PSRAM IP user port, backed
//            by a 2^MEM_AW x DATA_W on-chip memory. Fixed-length write and
//            read bursts, fixed read latency, init delay before init_calib,
//            and a minimum interval between accepted commands.
// Ports    : clk  - single clock
//            rst  - synchronous active-high reset
//            bus  - psram_if_responder_if.slave (command in, read data and
//                   status out)
// Revision : 1.0 - initial release
// ============================================================================
module psram_if_responder #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 64,
    parameter int BURST_BEATS = 32,
    parameter int RD_LATENCY  = 12,
    parameter int TCMD_MIN    = 50,
    parameter int INIT_CYCLES = 200,
    parameter int MEM_AW      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    psram_if_responder_if.slave  bus
);

    localparam int c_MASK_W    = DATA_W / 8;
    localparam int c_BEAT_W    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int c_TCMD_W    = $clog2(TCMD_MIN + 1);
    localparam int c_INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int c_WAIT_W    = $clog2(RD_LATENCY + 1);
    // RD_WAIT covers latency minus the READ-entry cycle and the memory
    // register stage; with RD_LATENCY==2 the wait state is skipped.
    localparam int c_WAIT_LAST = (RD_LATENCY > 2) ? RD_LATENCY - 3 : 0;

    localparam logic [c_TCMD_W-1:0] c_TCMD_MAX  = c_TCMD_W'(TCMD_MIN);
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYCLES - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_BEATS - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_END  = c_WAIT_W'(c_WAIT_LAST);

    typedef enum logic [2:0] {
        c_ST_INIT    = 3'd0,
        c_ST_IDLE    = 3'd1,
        c_ST_WRITE   = 3'd2,
        c_ST_RD_WAIT = 3'd3,
        c_ST_READ    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;

    logic [c_INIT_W-1:0]   r_init_cnt;
    logic [c_TCMD_W-1:0]   r_tcmd_cnt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [MEM_AW-1:0]     r_base;

    logic                  r_init_calib;
    logic                  r_cmd_err;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_rd_valid;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;

    logic [DATA_W-1:0]     r_mem [2**MEM_AW];

    logic [MEM_AW-1:0]     w_cmd_base;
    logic [MEM_AW-1:0]     w_beat_addr;
    logic [MEM_AW-1:0]     w_wr_addr;
    logic                  w_wr_en;
    logic                  w_unused_addr_bits;

    // One beat spans two 32-bit address units, so addr[0] drops out and
    // bits above the memory depth wrap silently.
    assign w_cmd_base         = bus.addr[MEM_AW:1];
    assign w_unused_addr_bits = ^{bus.addr[ADDR_W-1:MEM_AW+1], bus.addr[0]};
    assign w_beat_addr        = r_base + MEM_AW'(r_beat);

    // Beat 0 of a write lands in the accepting cycle itself, before the
    // base register has been loaded.
    assign w_wr_addr = (r_state == c_ST_IDLE) ? w_cmd_base : w_beat_addr;
    assign w_wr_en   = !rst && ((w_accept && bus.cmd) || (r_state == c_ST_WRITE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and command acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (bus.cmd_en && (r_tcmd_cnt == c_TCMD_MAX)) begin
                    w_accept = 1'b1;
                    if (bus.cmd) begin
                        w_state_nxt = c_ST_WRITE;
                    end else if (RD_LATENCY == 2) begin
                        w_state_nxt = c_ST_READ;
                    end else begin
                        w_state_nxt = c_ST_RD_WAIT;
                    end
                end
            end
            c_ST_WRITE: begin
                if (r_beat == c_BEAT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_WAIT: begin
                if (r_wait_cnt == c_WAIT_END) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (r_beat == c_BEAT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, status flags and read datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt   <= '0;
            r_tcmd_cnt   <= c_TCMD_MAX;
            r_wait_cnt   <= '0;
            r_beat       <= '0;
            r_base       <= '0;
            r_init_calib <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_wr_cnt     <= 16'd0;
            r_rd_cnt     <= 16'd0;
        end else begin
            r_rd_valid <= 1'b0;

            if (bus.cmd_en && !w_accept) begin
                r_cmd_err <= 1'b1;
            end

            // The accepting cycle counts as the first elapsed cycle, so a
            // command exactly TCMD_MIN cycles later sees the saturated value.
            if (w_accept) begin
                r_tcmd_cnt <= c_TCMD_W'(1);
            end else if (r_tcmd_cnt != c_TCMD_MAX) begin
                r_tcmd_cnt <= r_tcmd_cnt + c_TCMD_W'(1);
            end

            case (r_state)
                c_ST_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_init_calib <= 1'b1;
                        r_tcmd_cnt   <= c_TCMD_MAX;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_INIT_W'(1);
                    end
                end
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_base     <= w_cmd_base;
                        r_wait_cnt <= '0;
                        // Write beat 0 is already stored on acceptance.
                        r_beat     <= bus.cmd ? c_BEAT_W'(1) : '0;
                    end
                end
                c_ST_WRITE: begin
                    r_beat <= r_beat + c_BEAT_W'(1);
                    if (r_beat == c_BEAT_LAST) begin
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                end
                c_ST_RD_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                end
                c_ST_READ: begin
                    r_rd_data  <= r_mem[w_beat_addr];
                    r_rd_valid <= 1'b1;
                    r_beat     <= r_beat + c_BEAT_W'(1);
                    if (r_beat == c_BEAT_LAST) begin
                        r_rd_cnt <= r_rd_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Backing memory: byte-masked write port, contents survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_MASK_W; b++) begin
                if (!bus.data_mask[b]) begin
                    r_mem[w_wr_addr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign bus.init_calib    = r_init_calib;
    assign bus.cmd_err       = r_cmd_err;
    assign bus.wr_burst_cnt  = r_wr_cnt;
    assign bus.rd_burst_cnt  = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_psram_if_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_if_responder
// Purpose  : Directed self-checking bench for psram_if_responder. A
//            transaction-level model predicts every output each cycle; literal
//            expectations pin key beats, latencies and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_if_responder;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 64;
    localparam int B      = 32;
    localparam int L      = 12;
    localparam int TCMD   = 50;
    localparam int INIT   = 200;
    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psram_if_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    psram_if_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(B), .RD_LATENCY(L),
        .TCMD_MIN(TCMD), .INIT_CYCLES(INIT), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model. Cycle p is the interval after edge p.
    // A command driven in cycle c is judged at edge c+1.
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_live = 1'b0;
    int          m_rst_edge = 0;
    int          m_last_acc = -100000;
    bit          m_ok;
    bit          m_err = 1'b0;
    bit          m_wr_act = 1'b0, m_rd_act = 1'b0;
    int          m_wr_k, m_wr_base, m_rd_edge, m_rd_base, m_d, m_idx;
    bit          m_rd_valid = 1'b0;
    logic [63:0] m_rd_data = '0;
    logic [15:0] m_wr_cnt = '0, m_rd_cnt = '0;
    logic [63:0] m_mem [DEPTH];

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live     = 1'b1;
            m_rst_edge = cyc;
            m_last_acc = -100000;
            m_err      = 1'b0;
            m_wr_act   = 1'b0;
            m_rd_act   = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            m_wr_cnt   = '0;
            m_rd_cnt   = '0;
        end else begin
            // Ready once INIT cycles have fully elapsed before this edge,
            // and at least TCMD edges since the last accepted command.
            m_ok = ((cyc - m_rst_edge) > INIT) && ((cyc - m_last_acc) >= TCMD);
            m_rd_valid = 1'b0;
            if (bus.cmd_en) begin
                if (m_ok) begin
                    m_last_acc = cyc;
                    if (bus.cmd) begin
                        m_wr_act  = 1'b1;
                        m_wr_k    = 0;
                        m_wr_base = int'(bus.addr >> 1) % DEPTH;
                    end else begin
                        m_rd_act  = 1'b1;
                        m_rd_edge = cyc;
                        m_rd_base = int'(bus.addr >> 1) % DEPTH;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_wr_act) begin
                m_idx = (m_wr_base + m_wr_k) % DEPTH;
                for (int b = 0; b < DATA_W/8; b++)
                    if (!bus.data_mask[b]) m_mem[m_idx][b*8 +: 8] = bus.wr_data[b*8 +: 8];
                m_wr_k++;
                if (m_wr_k == B) begin
                    m_wr_act = 1'b0;
                    m_wr_cnt++;
                end
            end
            if (m_rd_act) begin
                // Beat k is visible L cycles after the command cycle, i.e.
                // after edge (accept edge + L - 1 + k).
                m_d = cyc - m_rd_edge - (L - 1);
                if (m_d >= 0) begin
                    m_rd_valid = 1'b1;
                    m_rd_data  = m_mem[(m_rd_base + m_d) % DEPTH];
                    if (m_d == B - 1) begin
                        m_rd_act = 1'b0;
                        m_rd_cnt++;
                    end
                end
            end
        end
    end

    // Single compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_live) begin
            check("rd_data_valid", 64'(bus.rd_data_valid), 64'(m_rd_valid));
            check("rd_data",       bus.rd_data,            m_rd_data);
            check("init_calib",    64'(bus.init_calib),    64'((cyc - m_rst_edge) >= INIT));
            check("cmd_err",       64'(bus.cmd_err),       64'(m_err));
            check("wr_burst_cnt",  64'(bus.wr_burst_cnt),  64'(m_wr_cnt));
            check("rd_burst_cnt",  64'(bus.rd_burst_cnt),  64'(m_rd_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [63:0] wdat [B];
    logic [7:0]  wmsk [B];
    logic [63:0] rbuf [B];
    int          rcount, first_lat, t_rel;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int p);
        while (cyc < p) step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst   = 1'b0;
        t_rel = cyc;
    endtask

    task automatic measure_init(input string nm);
        int rise = -1;
        for (int i = 0; i < INIT + 40 && rise < 0; i++) begin
            if (bus.init_calib) rise = cyc - t_rel;
            else step(1);
        end
        check(nm, 64'(rise), 64'(INIT));
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < B; k++) begin
            bus.cmd_en    = (k == 0);
            bus.cmd       = 1'b1;
            bus.addr      = a;
            bus.wr_data   = wdat[k];
            bus.data_mask = wmsk[k];
            step(1);
        end
        bus.cmd_en    = 1'b0;
        bus.cmd       = 1'b0;
        bus.wr_data   = '0;
        bus.data_mask = '0;
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] a, input int max_beats);
        int rc = cyc;
        first_lat  = -1;
        rcount     = 0;
        bus.cmd    = 1'b0;
        bus.addr   = a;
        bus.cmd_en = 1'b1;
        for (int i = 0; i < 100 && rcount < max_beats; i++) begin
            @(negedge clk);
            if (bus.rd_data_valid) begin
                if (rcount == 0) first_lat = cyc - rc;
                rbuf[rcount] = bus.rd_data;
                rcount++;
            end
            step(1);
            bus.cmd_en = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int c_iss;

    initial begin
        bus.cmd = 1'b0; bus.cmd_en = 1'b0; bus.addr = '0;
        bus.wr_data = '0; bus.data_mask = '0;
        for (int k = 0; k < B; k++) rbuf[k] = '0;

        // Reset values, then a command during INIT and the init delay.
        step(3);
        check("reset init_calib",    64'(bus.init_calib),    64'd0);
        check("reset rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
        check("reset rd_data",       bus.rd_data,            64'd0);
        check("reset cmd_err",       64'(bus.cmd_err),       64'd0);
        check("reset rd_burst_cnt",  64'(bus.rd_burst_cnt),  64'd0);
        rst   = 1'b0;
        t_rel = cyc;
        wait_until(t_rel + 100);
        bus.cmd_en = 1'b1; bus.cmd = 1'b0;
        step(1);
        bus.cmd_en = 1'b0;
        measure_init("init delay");
        check("cmd_en in INIT sets cmd_err", 64'(bus.cmd_err), 64'd1);

        // Write 0x1000+k at 0x40, read back 50 cycles later.
        do_reset();
        wait_until(t_rel + INIT);
        for (int k = 0; k < B; k++) begin wdat[k] = 64'h1000 + 64'(k); wmsk[k] = 8'h00; end
        c_iss = cyc;
        write_burst(21'h40);
        wait_until(c_iss + TCMD);
        c_iss = cyc;
        read_burst(21'h40, B);
        check("rd latency",      64'(first_lat), 64'(L));
        check("rd beat count",   64'(rcount),    64'(B));
        check("rd beat 0",       rbuf[0],        64'h1000);
        check("rd beat 31",      rbuf[31],       64'h101F);
        check("wr_burst_cnt 1",  64'(bus.wr_burst_cnt), 64'd1);
        check("rd_burst_cnt 1",  64'(bus.rd_burst_cnt), 64'd1);

        // Masked overwrite: even beats keep their low four bytes.
        wait_until(c_iss + TCMD);
        for (int k = 0; k < B; k++) begin wdat[k] = '1; wmsk[k] = (k % 2 == 0) ? 8'h0F : 8'h00; end
        c_iss = cyc;
        write_burst(21'h40);
        wait_until(c_iss + TCMD);
        c_iss = cyc;
        read_burst(21'h41, B);
        check("masked beat 0",  rbuf[0],  64'hFFFFFFFF_00001000);
        check("masked beat 1",  rbuf[1],  64'hFFFFFFFF_FFFFFFFF);
        check("masked beat 30", rbuf[30], 64'hFFFFFFFF_0000101E);
        check("cmd_err clear",  64'(bus.cmd_err), 64'd0);

        // Command interval: pulse at +49 rejected, at +50 accepted.
        wait_until(c_iss + TCMD);
        for (int k = 0; k < B; k++) begin wdat[k] = 64'hA000 + 64'(k); wmsk[k] = 8'h00; end
        c_iss = cyc;
        write_burst(21'h200);
        wait_until(c_iss + TCMD - 1);
        bus.cmd_en = 1'b1; bus.cmd = 1'b0; bus.addr = 21'h200;
        step(1);
        bus.cmd_en = 1'b0;
        check("interval 49 rejected", 64'(bus.cmd_err), 64'd1);
        c_iss = cyc;
        read_burst(21'h200, B);
        check("interval 50 latency", 64'(first_lat), 64'(L));
        check("interval 50 beat 0",  rbuf[0],  64'hA000);
        check("interval 50 beat 31", rbuf[31], 64'hA01F);

        // Wrap at the top of memory: base word 1020.
        wait_until(c_iss + TCMD);
        for (int k = 0; k < B; k++) begin wdat[k] = 64'hB000 + 64'(k); wmsk[k] = 8'h00; end
        c_iss = cyc;
        write_burst(21'd2040);
        wait_until(c_iss + TCMD);
        c_iss = cyc;
        read_burst(21'h0, B);
        check("wrap word 0",  rbuf[0],  64'hB004);
        check("wrap word 27", rbuf[27], 64'hB01F);
        check("wrap word 28", rbuf[28], 64'h0);
        check("wr_burst_cnt 4", 64'(bus.wr_burst_cnt), 64'd4);
        check("rd_burst_cnt 4", 64'(bus.rd_burst_cnt), 64'd4);

        // Reset five beats into a read burst.
        wait_until(c_iss + TCMD);
        do_reset();
        wait_until(t_rel + INIT);
        read_burst(21'h40, 5);
        check("abort beats seen", 64'(rcount), 64'd5);
        rst = 1'b1;
        step(1);
        check("abort rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
        check("abort rd_burst_cnt",  64'(bus.rd_burst_cnt),  64'd0);
        check("abort init_calib",    64'(bus.init_calib),    64'd0);
        rst   = 1'b0;
        t_rel = cyc;
        measure_init("re-init delay");
        step(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
